// File: rtl/attention_score_sequencer_if.sv
// Score stream between the attention score sequencer and the softmax stage.
// One transfer per score, row-major, valid/ready handshake.
interface attention_score_sequencer_if #(
  parameter int ACCW = 20,
  parameter int RW   = 2
);
  logic            s_valid;
  logic            s_ready;
  logic [ACCW-1:0] s_data;
  logic [RW-1:0]   s_row;
  logic [RW-1:0]   s_col;
  logic            s_last;

  modport master (output s_valid, s_data, s_row, s_col, s_last, input s_ready);
  modport slave  (input s_valid, s_data, s_row, s_col, s_last, output s_ready);
endinterface

// File: rtl/attention_score_sequencer.sv
// Computes S = Q*K^T for latched Q/K with one time-multiplexed LANES-wide
// dot-product lane and streams the scores row-major, with optional causal mask.
module attention_score_sequencer #(
  parameter int TOKENS = 4,
  parameter int DIM    = 16,
  parameter int DW     = 8,
  parameter int LANES  = 4,
  parameter int ACCW   = 2*DW + $clog2(DIM)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       mask_en,
  input  logic [TOKENS*DIM*DW-1:0]   q_in,
  input  logic [TOKENS*DIM*DW-1:0]   k_in,
  output logic                       busy,
  output logic                       done,
  attention_score_sequencer_if.master s
);

  localparam int CHUNKS = DIM / LANES;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int RW     = (TOKENS > 1) ? $clog2(TOKENS) : 1;
  localparam logic signed [ACCW-1:0] MASK_VAL = {1'b1, {(ACCW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, COMPUTE, OUTPUT} state_t;

  state_t                     state_q, state_d;
  logic [TOKENS*DIM*DW-1:0]   q_mat, k_mat;
  logic                       mask_q;
  logic [RW-1:0]              row, col, next_row, next_col;
  logic [CW-1:0]              chunk;
  logic signed [ACCW-1:0]     acc, psum, s_data_q;
  logic signed [2*DW-1:0]     prod [LANES];
  logic                       pair_last, next_masked, chunk_last;

  // One chunk of LANES products for the current (row, col) pair.
  // NOTE: combinational logic uses blocking '=' so psum accumulates in order
  // within the loop; registers below use '<=' so every flop samples old values.
  always_comb begin
    psum = '0;
    for (int l = 0; l < LANES; l++) begin
      prod[l] = (2*DW)'($signed(q_mat[((int'(row)*DIM) + int'(chunk)*LANES + l)*DW +: DW]))
              * (2*DW)'($signed(k_mat[((int'(col)*DIM) + int'(chunk)*LANES + l)*DW +: DW]));
      psum = psum + ACCW'(prod[l]);
    end
  end

  always_comb begin
    next_col = (col == RW'(TOKENS-1)) ? '0 : col + RW'(1);
    next_row = (col == RW'(TOKENS-1)) ? row + RW'(1) : row;
  end

  assign pair_last   = (row == RW'(TOKENS-1)) && (col == RW'(TOKENS-1));
  assign next_masked = mask_q && (next_col > next_row);
  assign chunk_last  = (chunk == CW'(CHUNKS-1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = COMPUTE;
      COMPUTE: if (chunk_last) state_d = OUTPUT;
      OUTPUT:
        if (s.s_ready) begin
          if (pair_last)        state_d = IDLE;
          else if (next_masked) state_d = OUTPUT;
          else                  state_d = COMPUTE;
        end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: q_mat/k_mat are wide data storage with no reset; their content is
  // irrelevant until the next start loads them.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q   <= 1'b0;
      row      <= '0;
      col      <= '0;
      chunk    <= '0;
      acc      <= '0;
      s_data_q <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE:
          if (start) begin
            q_mat  <= q_in;
            k_mat  <= k_in;
            mask_q <= mask_en;
            row    <= '0;
            col    <= '0;
            chunk  <= '0;
            acc    <= '0;
          end
        COMPUTE: begin
          acc   <= acc + psum;
          chunk <= chunk + CW'(1);
          if (chunk_last) s_data_q <= acc + psum;
        end
        OUTPUT:
          if (s.s_ready) begin
            if (pair_last) begin
              done <= 1'b1;
            end else begin
              row   <= next_row;
              col   <= next_col;
              acc   <= '0;
              chunk <= '0;
              if (next_masked) s_data_q <= MASK_VAL;
            end
          end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign s.s_valid = (state_q == OUTPUT);
  assign s.s_last  = (state_q == OUTPUT) && pair_last;
  assign s.s_data  = s_data_q;
  assign s.s_row   = row;
  assign s.s_col   = col;

endmodule

// File: tb/tb_attention_score_sequencer.sv
// Scoreboard bench for attention_score_sequencer: a reference model pushes
// expected scores, an independent monitor pops and compares on each handshake.
module tb_attention_score_sequencer;
  localparam int TOKENS = 4, DIM = 16, DW = 8, LANES = 4, ACCW = 20, RW = 2;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, mask_en = 1'b0;
  logic [TOKENS*DIM*DW-1:0] q_in = '0, k_in = '0;
  logic busy, done;

  attention_score_sequencer_if #(.ACCW(ACCW), .RW(RW)) s ();

  attention_score_sequencer #(.TOKENS(TOKENS), .DIM(DIM), .DW(DW), .LANES(LANES), .ACCW(ACCW)) dut (
    .clk(clk), .reset(reset), .start(start), .mask_en(mask_en),
    .q_in(q_in), .k_in(k_in), .busy(busy), .done(done), .s(s)
  );

  always #5 clk = ~clk;

  typedef struct { int row; int col; int data; } exp_t;

  int   errors = 0, checks = 0, cycle = 0;
  exp_t sb[$];
  int   qm[TOKENS][DIM], km[TOKENS][DIM];
  int   hs_edges[$], valid_rise[$];
  int   ready_mode = 0, stall_cycles = 0;

  always @(posedge clk) cycle++;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference: S[r][c] = sum_d Q[r][d]*K[c][d]; masked pairs give the most negative value.
  function automatic void push_expected(bit mask);
    for (int r = 0; r < TOKENS; r++)
      for (int c = 0; c < TOKENS; c++) begin
        exp_t e;
        e.row = r; e.col = c; e.data = 0;
        if (mask && c > r) e.data = -(1 << (ACCW-1));
        else for (int d = 0; d < DIM; d++) e.data += qm[r][d] * km[c][d];
        sb.push_back(e);
      end
  endfunction

  task automatic fill(int kind);
    for (int t = 0; t < TOKENS; t++)
      for (int d = 0; d < DIM; d++)
        case (kind)
          0: begin qm[t][d] = 1;    km[t][d] = 1;    end
          1: begin qm[t][d] = t+1;  km[t][d] = t+1;  end
          2: begin qm[t][d] = -128; km[t][d] = -128; end
          3: begin qm[t][d] = -128; km[t][d] = 127;  end
          default: begin
            qm[t][d] = int'($urandom_range(0, 255)) - 128;
            km[t][d] = int'($urandom_range(0, 255)) - 128;
          end
        endcase
    for (int t = 0; t < TOKENS; t++)
      for (int d = 0; d < DIM; d++) begin
        q_in[(t*DIM+d)*DW +: DW] = DW'(qm[t][d]);
        k_in[(t*DIM+d)*DW +: DW] = DW'(km[t][d]);
      end
  endtask

  // Consumer: always ready, random ready, or a single 10-cycle stall on pair (1,2).
  int stall_left = 0;
  bit stalled = 1'b0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: s.s_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (stall_left > 0) begin
          s.s_ready = 1'b0; stall_left--;
        end else if (!stalled && s.s_valid && s.s_row == 2'd1 && s.s_col == 2'd2) begin
          s.s_ready = 1'b0; stalled = 1'b1; stall_left = 9;
        end else s.s_ready = 1'b1;
      end
      default: begin s.s_ready = 1'b1; stalled = 1'b0; stall_left = 0; end
    endcase
  end

  // Monitor: scoreboard pop on every handshake, stall stability, timing records.
  bit prev_valid = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (s.s_valid && !prev_valid) valid_rise.push_back(cycle);
      if (ready_mode == 2 && s.s_valid && !s.s_ready && sb.size() > 0) begin
        stall_cycles++;
        check("stall_data", int'($signed(s.s_data)), sb[0].data);
        check("stall_pair", int'({s.s_row, s.s_col}), sb[0].row*4 + sb[0].col);
      end
      if (s.s_valid && s.s_ready) begin
        check("sb_nonempty", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("s_data", int'($signed(s.s_data)), e.data);
          check("s_row", int'(s.s_row), e.row);
          check("s_col", int'(s.s_col), e.col);
          check("s_last", int'(s.s_last), int'(e.row == 3 && e.col == 3));
        end
        hs_edges.push_back(cycle + 1);
      end
    end
    prev_valid = s.s_valid && !reset;
  end

  task automatic run_matrix(bit mask, int mode, bit timing, bit inject);
    int  c0, vb, hb, bad;
    bit  got;
    push_expected(mask);
    mask_en = mask;
    ready_mode = mode;
    vb = valid_rise.size();
    hb = hs_edges.size();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    c0 = cycle;
    if (inject) begin
      repeat (6) @(negedge clk);
      for (int i = 0; i < TOKENS*DIM*DW/32; i++) q_in[i*32 +: 32] = $urandom();
      mask_en = ~mask;
      start = 1'b1;
      @(negedge clk) start = 1'b0;
    end
    got = 1'b0;
    for (int n = 0; n < 4000 && !got; n++) begin
      if (done) got = 1'b1;
      else @(negedge clk);
    end
    check("done_seen", int'(got), 1);
    if (got && hs_edges.size() > hb) begin
      check("done_cycle", cycle, hs_edges[$]);
      check("score_count", hs_edges.size() - hb, 16);
      check("sb_drained", sb.size(), 0);
      @(negedge clk) check("done_width", int'(done), 0);
      if (timing) begin
        check("first_valid_latency", valid_rise[vb] - c0, 4);
        check("start_to_last", hs_edges[$] - c0, mask ? 56 : 80);
        if (!mask) begin
          bad = 0;
          for (int i = hb + 1; i < hs_edges.size(); i++)
            if (hs_edges[i] - hs_edges[i-1] != 5) bad++;
          check("score_spacing", bad, 0);
        end
      end
    end
    sb.delete();
  endtask

  task automatic reset_midrun();
    bit found, seen;
    fill(1);
    push_expected(1'b0);
    mask_en = 1'b0;
    ready_mode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 500 && !found; n++) begin
      if (busy && !s.s_valid && s.s_row == 2'd2 && s.s_col == 2'd1) found = 1'b1;
      else @(negedge clk);
    end
    check("reach_pair_2_1", int'(found), 1);
    reset = 1'b1;
    @(negedge clk);
    check("reset_midrun_outputs",
          int'({busy, done, s.s_valid, s.s_last, s.s_row, s.s_col, s.s_data}), 0);
    reset = 1'b0;
    sb.delete();
    seen = 1'b0;
    repeat (8) @(negedge clk) if (done || busy) seen = 1'b1;
    check("quiet_after_reset", int'(seen), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({busy, done, s.s_valid, s.s_last, s.s_row, s.s_col, s.s_data}), 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_reset", int'({busy, s.s_valid}), 0);

    fill(0); run_matrix(1'b0, 0, 1'b1, 1'b0);
    fill(1); run_matrix(1'b0, 0, 1'b1, 1'b0);
    fill(2); run_matrix(1'b0, 0, 1'b0, 1'b0);
    fill(3); run_matrix(1'b0, 1, 1'b0, 1'b0);
    fill(0); run_matrix(1'b1, 0, 1'b1, 1'b0);
    fill(1); run_matrix(1'b0, 2, 1'b0, 1'b0);
    check("stall_cycles", stall_cycles, 10);
    fill(4); run_matrix(1'b0, 0, 1'b1, 1'b1);
    reset_midrun();
    fill(4); run_matrix(1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      fill(4);
      run_matrix(bit'($urandom_range(0, 1)), 1, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cycle);
    $fatal(1, "watchdog");
  end
endmodule
